uart_cmd_parser: RTL

Frame decoder directly downstream of the UART receiver. Consumes the receiver's byte stream (8-bit data plus one-cycle data-valid pulse) and assembles framed controller commands: sync, command ID, length, payload, XOR checksum. Validated commands go to the game-logic side as a registered ID/payload with a one-cycle strobe. Malformed or stalled frames are dropped and reported with an error strobe and code.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_gap_timer.sv | 51 +++++
 rtl/uart_cmd_parser.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encodings, error codes and default sync byte for
//            the UART command-frame parser.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

   // Frame decoder states
   typedef enum logic [2:0] {
      s_SYNC    = 3'd0,
      s_ID      = 3'd1,
      s_LEN     = 3'd2,
      s_PAYLOAD = 3'd3,
      s_CHECK   = 3'd4
   } state_t;

   // Cause of the most recent dropped frame
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_LENGTH   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_gap_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_gap_timer
// Purpose  : Inter-byte gap counter. Counts while enabled, clears on i_CLEAR
//            or when disabled, and pulses o_EXPIRED for one cycle when the
//            count sits on its terminal value with no clear in that cycle.
// Revision : 1.0  initial release
// ============================================================================
module uart_gap_timer #(
   parameter int c_TERM_COUNT = 8680
) (
   input  logic i_CLK,
   input  logic i_RESET_N,
   input  logic i_CLEAR,
   input  logic i_ENABLE,
   output logic o_EXPIRED
);

   localparam int CNT_W = ($clog2(c_TERM_COUNT) > 0) ? $clog2(c_TERM_COUNT) : 1;
   localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(c_TERM_COUNT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_term;

   assign at_term = (cnt_q == TERM_VAL);

   // A clear in the terminal cycle suppresses expiry: the arriving byte wins.
   assign o_EXPIRED = i_ENABLE & ~i_CLEAR & at_term;

   // Next count: restart on clear/idle/expiry, otherwise advance.
   always_comb begin
      cnt_d = cnt_q;
      if (i_CLEAR || !i_ENABLE || at_term) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_gap_timer
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Purpose  : Assembles framed commands (sync, ID, length, payload, XOR
//            checksum) from the UART receiver byte stream. Good frames are
//            latched to the outputs with a strobe; bad or stalled frames are
//            dropped with an error strobe and cause code.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_parser
   import uart_pkg::*;
#(
   parameter int         c_MAX_LEN        = 4,
   parameter logic [7:0] c_SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         c_TIMEOUT_CYCLES = 8680
) (
   input  logic        i_CLK,
   input  logic        i_RESET_N,
   input  logic        i_RX_DV,
   input  logic [7:0]  i_RX_BYTE,
   output logic        o_FRAME_VALID,
   output logic [7:0]  o_CMD_ID,
   output logic [2:0]  o_LEN,
   output logic [31:0] o_PAYLOAD,
   output logic        o_FRAME_ERR,
   output logic [1:0]  o_ERR_CODE
);

   state_t       state_q, state_d;

   // Working frame being assembled
   logic [7:0]   id_q,   id_d;
   logic [2:0]   len_q,  len_d;
   logic [2:0]   idx_q,  idx_d;
   logic [31:0]  pay_q,  pay_d;
   logic [7:0]   acc_q,  acc_d;

   // Output registers
   logic         valid_q, valid_d;
   logic         err_q,   err_d;
   logic [1:0]   code_q,  code_d;
   logic [7:0]   cmd_q,   cmd_d;
   logic [2:0]   olen_q,  olen_d;
   logic [31:0]  opay_q,  opay_d;

   logic         w_expired;
   logic         w_in_frame;

   assign w_in_frame = (state_q != s_SYNC);

   uart_gap_timer #(
      .c_TERM_COUNT (c_TIMEOUT_CYCLES)
   ) u_gap_timer (
      .i_CLK     (i_CLK),
      .i_RESET_N (i_RESET_N),
      .i_CLEAR   (i_RX_DV),
      .i_ENABLE  (w_in_frame),
      .o_EXPIRED (w_expired)
   );

   // Next-state, datapath and output decisions for the frame decoder.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      len_d   = len_q;
      idx_d   = idx_q;
      pay_d   = pay_q;
      acc_d   = acc_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      cmd_d   = cmd_q;
      olen_d  = olen_q;
      opay_d  = opay_q;

      if (w_expired) begin
         state_d = s_SYNC;
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
      end else if (i_RX_DV) begin
         case (state_q)
            s_SYNC: begin
               if (i_RX_BYTE == c_SYNC_BYTE) begin
                  state_d = s_ID;
               end
            end
            s_ID: begin
               id_d    = i_RX_BYTE;
               acc_d   = i_RX_BYTE;
               state_d = s_LEN;
            end
            s_LEN: begin
               acc_d = acc_q ^ i_RX_BYTE;
               if (i_RX_BYTE > 8'(c_MAX_LEN)) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LENGTH;
                  state_d = s_SYNC;
               end else begin
                  // Zero-length frames also clear the payload so a good
                  // empty command presents an all-zero payload.
                  len_d   = i_RX_BYTE[2:0];
                  pay_d   = '0;
                  idx_d   = '0;
                  state_d = (i_RX_BYTE == 8'd0) ? s_CHECK : s_PAYLOAD;
               end
            end
            s_PAYLOAD: begin
               pay_d[{idx_q[1:0], 3'b000} +: 8] = i_RX_BYTE;
               acc_d = acc_q ^ i_RX_BYTE;
               idx_d = idx_q + 3'd1;
               if ((idx_q + 3'd1) == len_q) begin
                  state_d = s_CHECK;
               end
            end
            s_CHECK: begin
               if (i_RX_BYTE == acc_q) begin
                  cmd_d   = id_q;
                  olen_d  = len_q;
                  opay_d  = pay_q;
                  valid_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CHECKSUM;
               end
               state_d = s_SYNC;
            end
            default: begin
               state_d = s_SYNC;
            end
         endcase
      end
   end

   // Decoder state register.
   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         state_q <= s_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Working frame, accumulator and output registers.
   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         id_q    <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         pay_q   <= '0;
         acc_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         cmd_q   <= '0;
         olen_q  <= '0;
         opay_q  <= '0;
      end else begin
         id_q    <= id_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         pay_q   <= pay_d;
         acc_q   <= acc_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
         cmd_q   <= cmd_d;
         olen_q  <= olen_d;
         opay_q  <= opay_d;
      end
   end

   assign o_FRAME_VALID = valid_q;
   assign o_FRAME_ERR   = err_q;
   assign o_ERR_CODE    = code_q;
   assign o_CMD_ID      = cmd_q;
   assign o_LEN         = olen_q;
   assign o_PAYLOAD     = opay_q;

endmodule : uart_cmd_parser
`default_nettype wire
